// File: rtl/i_fetch_8bit_pkg.sv
// Shared CPU definitions for the instruction fetch path: widths, fetch FSM
// encoding and the SRAM byte-address helper.
package i_fetch_8bit_pkg;

    localparam int IMEM_AW = 9;
    localparam int IMEM_DW = 8;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_HI   = 3'd1;
    localparam logic [2:0] ST_RD_LO   = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_VALID   = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        RD_HI   = ST_RD_HI,
        RD_LO   = ST_RD_LO,
        WAIT_LO = ST_WAIT_LO,
        VALID   = ST_VALID
    } fetch_state_e;

    // Each instruction word occupies two bytes; the high byte sits at the even address.
    function automatic logic [IMEM_AW-1:0] byte_addr(input logic [PC_W-1:0] word_pc,
                                                     input logic            lo_byte);
        return {word_pc, lo_byte};
    endfunction

endpackage

// File: rtl/i_fetch_8bit_if.sv
// Decode handshake, loader port and SRAM pins of the instruction fetch unit.
// master = fetch unit side, slave = decode/loader/SRAM environment side.
interface i_fetch_8bit_if;
    import i_fetch_8bit_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [PC_W-1:0]    pc;

    logic               ld_valid;
    logic [IMEM_AW-1:0] ld_addr;
    logic [IMEM_DW-1:0] ld_data;
    logic               ld_ready;

    logic [IMEM_AW-1:0] mem_addr;
    logic               mem_we;
    logic [IMEM_DW-1:0] mem_wdata;
    logic [IMEM_DW-1:0] mem_rdata;

    modport master (
        output instr, instr_valid, pc, ld_ready, mem_addr, mem_we, mem_wdata,
        input  instr_ready, ld_valid, ld_addr, ld_data, mem_rdata
    );

    modport slave (
        input  instr, instr_valid, pc, ld_ready, mem_addr, mem_we, mem_wdata,
        output instr_ready, ld_valid, ld_addr, ld_data, mem_rdata
    );

endinterface

// File: rtl/i_fetch_8bit.sv
// Instruction fetch initiator: reads two bytes per instruction from the 8-bit
// SRAM, presents them big-endian to decode, and lets a loader fill the SRAM while idle.
//
// state   | meaning
// IDLE    | no fetch in flight; loader owns the SRAM write port
// RD_HI   | address of high byte presented
// RD_LO   | address of low byte presented; high byte captured
// WAIT_LO | low byte captured
// VALID   | instruction offered to decode, held until handshake
module i_fetch_8bit
    import i_fetch_8bit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    i_fetch_8bit_if.master    bus
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               load_go;
    logic               handshake;

    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;

    // Write strobes are gated by rst_n so nothing reaches the SRAM during reset.
    always_comb begin
        load_go       = rst_n && (state_q == IDLE) && bus.ld_valid;
        bus.ld_ready  = rst_n && (state_q == IDLE);
        bus.mem_we    = load_go;
        bus.mem_wdata = load_go ? bus.ld_data : '0;
        bus.mem_addr  = byte_addr(pc_q, 1'b0);
        case (state_q)
            IDLE:          if (load_go) bus.mem_addr = bus.ld_addr;
            RD_LO, WAIT_LO: bus.mem_addr = byte_addr(pc_q, 1'b1);
            default:       bus.mem_addr = byte_addr(pc_q, 1'b0);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        handshake = instr_valid_q && bus.instr_ready;

        case (state_q)
            IDLE: begin
                if (!bus.ld_valid && fetch_en) state_d = RD_HI;
            end
            RD_HI: state_d = RD_LO;
            RD_LO: begin
                instr_d[15:8] = bus.mem_rdata;
                state_d       = WAIT_LO;
            end
            WAIT_LO: begin
                instr_d[7:0] = bus.mem_rdata;
                state_d      = VALID;
            end
            VALID: begin
                if (handshake) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = fetch_en ? RD_HI : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect wins over both the increment and any partial capture.
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = instr_q;
            state_d = fetch_en ? RD_HI : IDLE;
        end

        instr_valid_d = (state_d == VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_i_fetch_8bit.sv
// Scoreboard bench for i_fetch_8bit with a behavioural 512x8 registered-read SRAM.
module tb_i_fetch_8bit;
    import i_fetch_8bit_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_en = 1'b0;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;

    i_fetch_8bit_if bus ();

    i_fetch_8bit #(.RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else            bus.mem_rdata     <= mem[bus.mem_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_hs = 0;
    logic [23:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            n_hs++;
            if (sb_q.size() == 0) begin
                chk("unexpected_instr", {8'h00, bus.instr, bus.pc}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                chk("sb_instr_pc", {8'h00, bus.instr, bus.pc}, {8'h00, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic [8:0] a, input logic [7:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        #1;
        if (!bus.ld_ready || !bus.mem_we || bus.mem_addr !== a)
            chk("loader_accept", {bus.ld_ready, bus.mem_we, bus.mem_addr}, {1'b1, 1'b1, a});
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.instr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.instr_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int t0;
        logic [15:0] held_instr;
        logic [7:0]  held_pc;
        logic [8:0]  la [10];
        logic [7:0]  ld [10];

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        bus.instr_ready = 1'b0;
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = 9'h1AA;
        bus.ld_data     = 8'h77;

        // Reset values, including a loader request held during reset.
        #12;
        chk("rst_pc", bus.pc, 8'h00);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_ld_ready", bus.ld_ready, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 9'h000);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
        bus.ld_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        la = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd186, 9'd187};
        ld = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hAD};
        for (int i = 0; i < 10; i++) load(la[i], ld[i]);
        load(9'd510, 8'hC0);
        load(9'd511, 8'hDE);
        chk("sram_not_written_in_reset", mem[9'h1AA], 8'h00);

        // Basic fetch, latency and throughput; fetch_en drops during the second fetch.
        sb_q.push_back({16'h1234, 8'h00});
        sb_q.push_back({16'hABCD, 8'h01});
        bus.instr_ready = 1'b1;
        fetch_en = 1'b1;
        wait_valid(n);
        chk("first_latency", n, 4);
        t0 = cyc;
        tick();
        fetch_en = 1'b0;
        wait_valid(n);
        chk("throughput", cyc - t0, 4);
        tick();
        tick();
        chk("idle_after_en_drop", bus.instr_valid, 1'b0);
        chk("pc_after_two", bus.pc, 8'h02);

        // Stall in VALID for 5 cycles with a loader request that must be ignored.
        bus.instr_ready = 1'b0;
        fetch_en = 1'b1;
        wait_valid(n);
        fetch_en = 1'b0;
        held_instr = 16'h5678;
        held_pc = 8'h02;
        bus.ld_valid = 1'b1;
        bus.ld_addr = 9'd300;
        bus.ld_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.instr !== held_instr || bus.pc !== held_pc || !bus.instr_valid
                || bus.mem_we || bus.ld_ready)
                chk("stall_stable", {bus.instr_valid, bus.mem_we, bus.ld_ready, bus.instr, bus.pc},
                    {1'b1, 1'b0, 1'b0, held_instr, held_pc});
        end
        chk("stall_stable_final", {bus.instr, bus.pc}, {held_instr, held_pc});
        bus.ld_valid = 1'b0;
        sb_q.push_back({16'h5678, 8'h02});
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("pc_after_release", bus.pc, 8'h03);
        chk("stall_no_write", mem[300], 8'h00);

        // Redirect coincident with a handshake at pc=3, then fetch through the wrap.
        fetch_en = 1'b1;
        wait_valid(n);
        chk("pc3_valid", bus.pc, 8'h03);
        sb_q.push_back({16'h9ABC, 8'h03});
        t0 = n_hs;
        bus.instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        chk("redirect_over_inc", bus.pc, 8'hFF);
        chk("one_consumed", n_hs - t0, 1);
        sb_q.push_back({16'hC0DE, 8'hFF});
        sb_q.push_back({16'h1234, 8'h00});
        sb_q.push_back({16'hDEAD, 8'h5D});

        // Redirect during RD_LO of the pc=1 fetch; that fetch must not surface.
        n = 0;
        while (!(bus.pc == 8'h01 && !bus.instr_valid) && n < 50) begin
            tick();
            n++;
        end
        chk("reach_pc1", bus.pc, 8'h01);
        tick();
        redirect = 1'b1;
        redirect_pc = 8'h5D;
        tick();
        redirect = 1'b0;
        fetch_en = 1'b0;
        chk("redirect_mid_valid", bus.instr_valid, 1'b0);
        chk("redirect_mid_pc", bus.pc, 8'h5D);
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("sb_drained", sb_q.size(), 0);
        tick();
        chk("pc_after_5d", bus.pc, 8'h5E);

        // Asynchronous reset during WAIT_LO.
        bus.instr_ready = 1'b0;
        fetch_en = 1'b1;
        tick();
        tick();
        tick();
        #2;
        bus.ld_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.instr_valid, 1'b0);
        chk("async_rst_pc", bus.pc, 8'h00);
        chk("async_rst_we", bus.mem_we, 1'b0);
        chk("async_rst_ld_ready", bus.ld_ready, 1'b0);
        tick();
        tick();
        chk("rst_hold_valid", bus.instr_valid, 1'b0);
        bus.ld_valid = 1'b0;
        fetch_en = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("sb_final_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i_fetch_8bit.md
# i_fetch_8bit

Instruction fetch initiator for the 8-bit, 512-entry instruction SRAM. It drives the SRAM's address, write-enable and write-data pins and consumes its registered read data (1-cycle read latency). It assembles two consecutive bytes into one 16-bit instruction and hands it to the CPU decode stage over a valid/ready handshake. It also provides a byte-write loader port that fills the SRAM while fetching is idle.

## Interface
Parameters:
- `RESET_PC`, 8'h00: instruction (word) address loaded into `pc` on reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `fetch_en`, input, 1: permits new fetches.
- `redirect`, input, 1: single-cycle branch/jump request.
- `redirect_pc`, input, 8: new word address, valid with `redirect`.
- `instr`, output, 16: fetched instruction, `{byte[2pc], byte[2pc+1]}` (big-endian).
- `instr_valid`, output, 1: `instr` and `pc` are valid.
- `instr_ready`, input, 1: decode accepts `instr` this cycle.
- `pc`, output, 8: word address of `instr` / current fetch.
- `ld_valid`, input, 1: loader write request.
- `ld_addr`, input, 9: loader byte address.
- `ld_data`, input, 8: loader byte.
- `ld_ready`, output, 1: loader write accepted this cycle.
- `mem_addr`, output, 9: SRAM byte address.
- `mem_we`, output, 1: SRAM write enable.
- `mem_wdata`, output, 8: SRAM write data.
- `mem_rdata`, input, 8: SRAM registered read data, valid the cycle after an address is presented with `mem_we`=0.

## Operation
- FSM states: IDLE, RD_HI, RD_LO, WAIT_LO, VALID.
- IDLE:
  - `ld_ready`=1.
  - If `ld_valid`: `mem_we`=1, `mem_addr`=`ld_addr`, `mem_wdata`=`ld_data`; stay in IDLE. The load has priority over `fetch_en`.
  - Otherwise, if `fetch_en`: go to RD_HI.
- RD_HI: `mem_addr`={pc,0}; go to RD_LO.
- RD_LO: `mem_addr`={pc,1}; capture `mem_rdata` into the high byte; go to WAIT_LO.
- WAIT_LO: `mem_addr`={pc,1}; capture `mem_rdata` into the low byte; go to VALID.
- VALID: `instr_valid`=1; `instr` is held stable until handshake.
  - On handshake (`instr_valid & instr_ready`): `pc`<=`pc`+1 (wraps 8'hFF to 8'h00).
  - After handshake: go to RD_HI if `fetch_en`=1, else IDLE.
- Outside IDLE: `ld_ready`=0, `mem_we`=0. In IDLE without a load: `mem_addr`={pc,0}, `mem_wdata`=0.
- Redirect (any state, including mid-fetch):
  - `pc`<=`redirect_pc`; partial bytes are discarded; `instr_valid` is 0 from the next cycle.
  - Next state is RD_HI if `fetch_en`, else IDLE.
  - Redirect in the same cycle as a handshake: the handshake completes (instruction consumed), then `redirect_pc` overrides the increment.
- `fetch_en` falling mid-fetch: the current fetch completes to VALID; no new fetch starts.
- Reset mid-operation: immediately returns to IDLE with outputs at reset values. SRAM contents are not this block's concern.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=16'h0000, `instr_valid`=0.
  - State IDLE.
  - `mem_we`=0, `ld_ready`=0 while `rst_n`=0 (both gated by `rst_n`); `mem_addr`={RESET_PC,0}, `mem_wdata`=0.
- `mem_addr`, `mem_we`, `mem_wdata` and `ld_ready` are combinational from state, `pc` and the loader inputs. `instr`, `instr_valid` and `pc` are registered.
- Fetch latency: entering RD_HI at cycle N gives `instr_valid`=1 at cycle N+3.
- Back-to-back throughput with `instr_ready` held at 1: one instruction per 4 cycles.
- Loader: one byte per cycle while in IDLE.

## Structure
- Shared CPU package holds:
  - FSM state encoding (3-bit localparams).
  - Widths: `IMEM_AW`=9, `IMEM_DW`=8, `INSTR_W`=16, `PC_W`=8.
- Single module, no sub-module. The testbench instantiates the existing 8-bit SRAM model as the memory.

## Test plan
- Loader writes bytes 8'h12, 8'h34, 8'hAB, 8'hCD to addresses 0 to 3, then `fetch_en`=1 with `instr_ready`=1 -> `instr`=16'h1234 with `pc`=0, then `instr`=16'hABCD with `pc`=1; first `instr_valid` 3 cycles after RD_HI.
- Hold `instr_ready`=0 for 5 cycles in VALID -> `instr` and `pc` stable, `mem_we`=0, `ld_ready`=0; release -> `pc` increments once.
- `redirect`=1, `redirect_pc`=8'h5D during RD_LO -> partial fetch dropped; next `instr`={mem[186],mem[187]} with `pc`=8'h5D.
- Redirect coincident with a handshake at `pc`=3 -> `pc`=`redirect_pc`, not 4; exactly one instruction consumed.
- `pc`=8'hFF handshake -> next fetch reads bytes 510 and 511, then `pc` wraps to 8'h00 reading bytes 0 and 1.
- Assert `rst_n`=0 during WAIT_LO -> `instr_valid`=0, `pc`=`RESET_PC` immediately (asynchronous); `ld_valid`=1 while in reset gives no `mem_we`.
